// File: rtl/filt_seq.sv
// filt_seq: sequences one upstream sample at a time through a ring-buffer
// write and a filter ap_start/ap_done handshake, then queues the filter
// result in a small first-word-fall-through FIFO for the downstream side.
// Every output is a register; its next value is derived from the next state.
module filt_seq #(
  parameter int DATA_SIZE  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 s_ready,
  output logic                 rbuf_en,
  output logic [DATA_SIZE-1:0] rbuf_di,
  input  logic                 rbuf_done,
  output logic                 filt_start,
  input  logic                 filt_ready,
  input  logic                 filt_done,
  input  logic [DATA_SIZE-1:0] filt_result,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  input  logic                 m_ready,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          ovf_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_WAIT_RBUF, ST_START, ST_WAIT_DONE
  } state_t;

  state_t               r_state, w_state_n;
  logic [CW-1:0]        r_wcnt, w_wcnt_n;
  logic                 w_accept, w_push, w_pop, w_to, w_wait_exp;

  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wptr, r_rptr, w_wptr_n, w_rptr_n, w_cnt_n;
  logic [DATA_SIZE-1:0] w_m_data_n;

  logic                 r_s_ready, r_rbuf_en, r_filt_start, r_m_valid;
  logic                 r_busy, r_timeout_err;
  logic [DATA_SIZE-1:0] r_rbuf_di, r_m_data;
  logic [15:0]          r_ovf_cnt;

  assign s_ready     = r_s_ready;
  assign rbuf_en     = r_rbuf_en;
  assign rbuf_di     = r_rbuf_di;
  assign filt_start  = r_filt_start;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign ovf_cnt     = r_ovf_cnt;

  // Wait budget is spent once the counter has seen TIMEOUT cycles in a wait state.
  assign w_wait_exp = (r_wcnt == CW'(TIMEOUT - 1));

  // Next-state logic; the wait counter restarts on every entry into a wait state.
  always_comb begin
    w_state_n = r_state;
    w_wcnt_n  = r_wcnt + 1'b1;
    w_accept  = 1'b0;
    w_push    = 1'b0;
    w_to      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wcnt_n = '0;
        if (s_valid && r_s_ready) begin
          w_accept  = 1'b1;
          w_state_n = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_wcnt_n  = '0;
        w_state_n = ST_WAIT_RBUF;
      end
      ST_WAIT_RBUF: begin
        if (rbuf_done) begin
          w_wcnt_n  = '0;
          w_state_n = ST_START;
        end else if (w_wait_exp) begin
          w_wcnt_n  = '0;
          w_to      = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (filt_ready && filt_done) begin
          // Filter finished in the same cycle it accepted the start.
          w_wcnt_n  = '0;
          w_push    = 1'b1;
          w_state_n = ST_IDLE;
        end else if (filt_ready) begin
          w_wcnt_n  = '0;
          w_state_n = ST_WAIT_DONE;
        end else if (w_wait_exp) begin
          w_wcnt_n  = '0;
          w_to      = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (filt_done) begin
          w_wcnt_n  = '0;
          w_push    = 1'b1;
          w_state_n = ST_IDLE;
        end else if (w_wait_exp) begin
          w_wcnt_n  = '0;
          w_to      = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      default: begin
        w_wcnt_n  = '0;
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // FIFO next pointers and the head word that will be visible next cycle.
  // Admission only happens with a free slot, so a push never meets a full FIFO.
  always_comb begin
    w_pop    = r_m_valid && m_ready;
    w_wptr_n = r_wptr + {{AW{1'b0}}, w_push};
    w_rptr_n = r_rptr + {{AW{1'b0}}, w_pop};
    w_cnt_n  = w_wptr_n - w_rptr_n;
    // If the new head slot is the one being written now, bypass the memory.
    if (w_push && (w_rptr_n[AW-1:0] == r_wptr[AW-1:0]))
      w_m_data_n = filt_result;
    else
      w_m_data_n = r_mem[w_rptr_n[AW-1:0]];
  end

  // Result storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= filt_result;
  end

  // State, counters, pointers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wcnt        <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_s_ready     <= 1'b0;
      r_rbuf_en     <= 1'b0;
      r_rbuf_di     <= '0;
      r_filt_start  <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_ovf_cnt     <= '0;
    end else begin
      r_state      <= w_state_n;
      r_wcnt       <= w_wcnt_n;
      r_wptr       <= w_wptr_n;
      r_rptr       <= w_rptr_n;
      r_s_ready    <= (w_state_n == ST_IDLE) && (w_cnt_n != (AW+1)'(FIFO_DEPTH));
      r_rbuf_en    <= (w_state_n == ST_WRITE);
      r_filt_start <= (w_state_n == ST_START);
      r_busy       <= (w_state_n != ST_IDLE);
      r_m_valid    <= (w_cnt_n != '0);
      r_m_data     <= w_m_data_n;
      if (w_accept) r_rbuf_di <= s_data;
      if (w_to)         r_timeout_err <= 1'b1;
      else if (err_clr) r_timeout_err <= 1'b0;
      if (s_valid && !r_s_ready && (r_ovf_cnt != 16'hFFFF))
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_filt_seq.sv
// Self-checking bench for filt_seq: the bench plays ring buffer and filter,
// and a scoreboard queue holds every result the filter handed over, in order.
module tb_filt_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        rbuf_en;
  logic [15:0] rbuf_di;
  logic        rbuf_done = 1'b0;
  logic        filt_start;
  logic        filt_ready = 1'b0;
  logic        filt_done = 1'b0;
  logic [15:0] filt_result = '0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic [15:0] ovf_cnt;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          ovf_exp = 0;
  bit          rnd_mready = 1'b0;
  logic [15:0] exp_q[$];

  filt_seq #(.DATA_SIZE(16), .FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rbuf_en(rbuf_en), .rbuf_di(rbuf_di), .rbuf_done(rbuf_done),
    .filt_start(filt_start), .filt_ready(filt_ready), .filt_done(filt_done),
    .filt_result(filt_result),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Downstream scoreboard: every handshake must deliver the oldest expected result.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_order: popped %h while no result expected", m_data);
      end else begin
        if (m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL pop_order: m_data=%h required %h", m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        pops++;
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mready) m_ready = 1'($urandom_range(0, 1));
  endtask

  // One complete sample transaction, bench acting as ring buffer and filter.
  task automatic send(input logic [15:0] d, input int rd, input int fd,
                      input logic [15:0] res, input bit same);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: s_ready=%b required 1", s_ready);
      return;
    end
    s_valid = 1'b1; s_data = d;
    tick();
    s_valid = 1'b0; s_data = 16'($urandom);
    checks++;
    if (rbuf_en !== 1'b1 || rbuf_di !== d || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse: rbuf_en=%b rbuf_di=%h s_ready=%b required 1 %h 0",
               rbuf_en, rbuf_di, s_ready, d);
    end
    tick();
    checks++;
    if (rbuf_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_once: rbuf_en=%b busy=%b required 0 1", rbuf_en, busy);
    end
    repeat (rd) tick();
    rbuf_done = 1'b1;
    tick();
    rbuf_done = 1'b0;
    checks++;
    if (filt_start !== 1'b1) begin
      errors++;
      $display("FAIL start_high: filt_start=%b required 1", filt_start);
    end
    if (same) begin
      filt_ready = 1'b1; filt_done = 1'b1; filt_result = res;
      tick();
      filt_ready = 1'b0; filt_done = 1'b0;
      exp_q.push_back(res);
      checks++;
      if (busy !== 1'b0 || filt_start !== 1'b0) begin
        errors++;
        $display("FAIL same_edge_idle: busy=%b filt_start=%b required 0 0", busy, filt_start);
      end
    end else begin
      filt_ready = 1'b1;
      tick();
      filt_ready = 1'b0;
      checks++;
      if (filt_start !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL start_drop: filt_start=%b busy=%b required 0 1", filt_start, busy);
      end
      repeat (fd) tick();
      filt_done = 1'b1; filt_result = res;
      tick();
      filt_done = 1'b0;
      exp_q.push_back(res);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL done_idle: busy=%b required 0", busy);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid !== 1'b0) && n < 60) begin tick(); n++; end
    checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: %0d results left, m_valid=%b required 0 0", exp_q.size(), m_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0 || rbuf_en !== 1'b0 ||
        filt_start !== 1'b0 || timeout_err !== 1'b0 || ovf_cnt !== 16'd0 ||
        rbuf_di !== 16'd0 || m_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: s_ready=%b busy=%b m_valid=%b rbuf_en=%b filt_start=%b terr=%b ovf=%0d di=%h md=%h required all 0",
               s_ready, busy, m_valid, rbuf_en, filt_start, timeout_err, ovf_cnt, rbuf_di, m_data);
    end
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: s_ready=%b required 1", s_ready);
    end
  endtask

  task automatic test_single();
    m_ready = 1'b0;
    send(16'h0123, 2, 5, 16'h0ABC, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h0ABC || rbuf_di !== 16'h0123) begin
      errors++;
      $display("FAIL single: m_valid=%b m_data=%h rbuf_di=%h required 1 0abc 0123",
               m_valid, m_data, rbuf_di);
    end
    drain();
  endtask

  task automatic test_full();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
           16'($urandom), 1'($urandom_range(0, 1)));
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== exp_q[0]) begin
      errors++;
      $display("FAIL full: s_ready=%b m_valid=%b m_data=%h required 0 1 %h",
               s_ready, m_valid, m_data, exp_q[0]);
    end
    s_valid = 1'b1;
    repeat (10) tick();
    s_valid = 1'b0;
    ovf_exp += 10;
    checks++;
    if (ovf_cnt !== 16'(ovf_exp)) begin
      errors++;
      $display("FAIL ovf_cnt: got %0d required %0d", ovf_cnt, ovf_exp);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || m_data !== exp_q[0]) begin
      errors++;
      $display("FAIL pop_frees: s_ready=%b m_data=%h required 1 %h", s_ready, m_data, exp_q[0]);
    end
    drain();
  endtask

  task automatic test_same_edge();
    m_ready = 1'b1;
    send(16'h5A5A, 0, 0, 16'hC3C3, 1'b1);
    send(16'h1111, 1, 0, 16'h2222, 1'b0);
    drain();
  endtask

  task automatic test_timeout();
    int n;
    m_ready = 1'b1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_ready: s_ready=%b required 1", s_ready);
    end
    s_valid = 1'b1; s_data = 16'hBEEF;
    tick();
    s_valid = 1'b0;
    tick();
    repeat (200) tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: timeout_err=%b busy=%b required 0 1", timeout_err, busy);
    end
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_fire: timeout_err=%b busy=%b m_valid=%b s_ready=%b required 1 0 0 1",
               timeout_err, busy, m_valid, s_ready);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: timeout_err=%b required 1", timeout_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: timeout_err=%b required 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h7777;
    tick();
    s_valid = 1'b0;
    tick();
    rbuf_done = 1'b1;
    tick();
    rbuf_done = 1'b0;
    filt_ready = 1'b1;
    tick();
    filt_ready = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || filt_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait: busy=%b filt_start=%b required 1 0", busy, filt_start);
    end
    #2 rst = 1'b1;
    #1;
    ovf_exp = 0;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || rbuf_en !== 1'b0 || filt_start !== 1'b0 ||
        timeout_err !== 1'b0 || ovf_cnt !== 16'd0 || rbuf_di !== 16'd0 || m_data !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b m_valid=%b rbuf_en=%b filt_start=%b terr=%b ovf=%0d di=%h md=%h required all 0",
               busy, m_valid, rbuf_en, filt_start, timeout_err, ovf_cnt, rbuf_di, m_data);
    end
    tick();
    rst = 1'b0;
    filt_done = 1'b1; filt_result = 16'hDEAD;
    tick();
    tick();
    filt_done = 1'b0;
    repeat (4) tick();
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ignore: m_valid=%b busy=%b s_ready=%b required 0 0 1", m_valid, busy, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pops;
    rnd_mready = 1'b1;
    for (int i = 0; i < 20; i++)
      send(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           16'($urandom), 1'($urandom_range(0, 1)));
    rnd_mready = 1'b0;
    drain();
    checks++;
    if (pops - p0 != 20) begin
      errors++;
      $display("FAIL stream_count: popped %0d required 20", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_same_edge();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
